writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/writeback.sv
// Writeback stage: 8x8 register file with write bypass, condition/overflow flags,
// retired-instruction counter and a handshaked output-port write path.
module writeback (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  result,
    input  logic        shift_overflow,
    input  logic        arithmetic_overflow,
    input  logic [3:0]  dest_sel,
    input  logic        is_cond,
    input  logic [2:0]  rd_addr_a,
    input  logic [2:0]  rd_addr_b,
    output logic [7:0]  rd_data_a,
    output logic [7:0]  rd_data_b,
    output logic [7:0]  port_data,
    output logic        port_req,
    input  logic        port_ack,
    output logic        branch_taken,
    output logic [2:0]  flags,
    input  logic        flags_clear,
    output logic [15:0] retired
);

    typedef enum logic {
        IDLE      = 1'b0,
        PORT_WAIT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  regs_r [8];
    logic [7:0]  port_data_r;
    logic        branch_r;
    logic        zero_r;
    logic        arith_ovf_r;
    logic        shift_ovf_r;
    logic [15:0] retired_r;

    logic        accept_s;
    logic        wr_en_s;
    logic        port_wr_s;
    logic        zero_upd_s;

    // Accept decode uses the state register directly to avoid a loop through in_ready.
    always_comb begin
        accept_s   = in_valid && (state_r == IDLE);
        wr_en_s    = accept_s && !is_cond && (dest_sel[3] == 1'b0);
        port_wr_s  = accept_s && !is_cond && (dest_sel == 4'b1000);
        zero_upd_s = wr_en_s || port_wr_s;
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_next_s = state_r;
        in_ready     = 1'b0;
        port_req     = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (port_wr_s) begin
                    state_next_s = PORT_WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PORT_WAIT: begin
                port_req = 1'b1;
                if (port_ack) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PORT_WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Register file writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            regs_r[dest_sel[2:0]] <= result;
        end
    end

    // Combinational reads; a same-cycle write to the addressed register bypasses the array.
    always_comb begin
        if (wr_en_s && (dest_sel[2:0] == rd_addr_a)) begin
            rd_data_a = result;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
        if (wr_en_s && (dest_sel[2:0] == rd_addr_b)) begin
            rd_data_b = result;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

    // Port data, branch pulse, flags and retired counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            port_data_r <= 8'h00;
            branch_r    <= 1'b0;
            zero_r      <= 1'b0;
            arith_ovf_r <= 1'b0;
            shift_ovf_r <= 1'b0;
            retired_r   <= 16'h0000;
        end else begin
            if (port_wr_s) begin
                port_data_r <= result;
            end
            branch_r <= accept_s && is_cond && result[0];
            if (zero_upd_s) begin
                zero_r <= (result == 8'h00);
            end
            // A set in the same cycle as a clear wins.
            if (accept_s && arithmetic_overflow) begin
                arith_ovf_r <= 1'b1;
            end else if (flags_clear) begin
                arith_ovf_r <= 1'b0;
            end
            if (accept_s && shift_overflow) begin
                shift_ovf_r <= 1'b1;
            end else if (flags_clear) begin
                shift_ovf_r <= 1'b0;
            end
            if (accept_s) begin
                retired_r <= retired_r + 16'd1;
            end
        end
    end

    assign port_data    = port_data_r;
    assign branch_taken = branch_r;
    assign flags        = {zero_r, arith_ovf_r, shift_ovf_r};
    assign retired      = retired_r;

endmodule
